// File: rtl/vdp_palette_pkg.sv
// Colour back-end constants: screen mode codes, reset palette, G7 sprite colours, channel expansion.
// Latency: none (definitions only).
// Backpressure: not applicable.
package vdp_palette_pkg;

  // Screen mode codes, same encoding as the timing controller.
  localparam logic [4:0] MODE_G1 = 5'b00000;
  localparam logic [4:0] MODE_T1 = 5'b00001;
  localparam logic [4:0] MODE_MC = 5'b00010;
  localparam logic [4:0] MODE_G2 = 5'b00100;
  localparam logic [4:0] MODE_G3 = 5'b01000;
  localparam logic [4:0] MODE_T2 = 5'b01001;
  localparam logic [4:0] MODE_G4 = 5'b01100;
  localparam logic [4:0] MODE_G5 = 5'b10000;
  localparam logic [4:0] MODE_G6 = 5'b10100;
  localparam logic [4:0] MODE_G7 = 5'b11100;

  // Palette entries are packed {R,G,B}, 3 bits each, so each octal literal reads R,G,B.
  localparam logic [8:0] PAL_DEFAULT [16] = '{
    9'o000, 9'o000, 9'o161, 9'o373, 9'o117, 9'o237, 9'o511, 9'o267,
    9'o711, 9'o733, 9'o661, 9'o664, 9'o141, 9'o625, 9'o555, 9'o777
  };

  // Fixed G7 sprite colours, stored in the same GGGRRRBB byte format as G7 pixels.
  localparam logic [7:0] G7_SPRITE [16] = '{
    8'h00, 8'h01, 8'h0C, 8'h0D, 8'h60, 8'h61, 8'h6C, 8'h6D,
    8'h9D, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF
  };

  // Palette write byte phase: colour byte (R/B) first, then G byte.
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  // Stretch a 3-bit level to 5 bits so 0 -> 0 and 7 -> 31.
  function automatic logic [4:0] expand3to5(input logic [2:0] c);
    return {c, c[2:1]};
  endfunction

endpackage

// File: rtl/vdp_palette_writer.sv
// CPU palette write path: R#16 index, two-byte entry assembly, 16x9 flop storage with comb read port.
// Latency: entry visible on the read port the cycle after the second byte's edge.
// Backpressure: none; strobes are always accepted, index write wins over a simultaneous data byte.
module vdp_palette_writer
  import vdp_palette_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       index_wr_i,
  input  logic [3:0] index_i,
  input  logic       data_wr_i,
  input  logic [7:0] data_i,
  input  logic [3:0] rd_idx_i,
  output logic [8:0] rd_dat_o
);

  phase_e     phase_q, phase_d;
  logic [3:0] index_q, index_d;
  logic [2:0] r_lat_q, r_lat_d;
  logic [2:0] b_lat_q, b_lat_d;
  logic [8:0] pal_q [16];
  logic [8:0] pal_d [16];

  // Write state and storage; reset reloads the default palette.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_FIRST;
      index_q <= '0;
      r_lat_q <= '0;
      b_lat_q <= '0;
      for (int i = 0; i < 16; i++) pal_q[i] <= PAL_DEFAULT[i];
    end else begin
      phase_q <= phase_d;
      index_q <= index_d;
      r_lat_q <= r_lat_d;
      b_lat_q <= b_lat_d;
      pal_q   <= pal_d;
    end
  end

  // Next state: index write resets the byte phase; second byte commits and auto-increments.
  always_comb begin
    phase_d = phase_q;
    index_d = index_q;
    r_lat_d = r_lat_q;
    b_lat_d = b_lat_q;
    pal_d   = pal_q;
    if (index_wr_i) begin
      index_d = index_i;
      phase_d = PH_FIRST;
    end else if (data_wr_i) begin
      if (phase_q == PH_FIRST) begin
        r_lat_d = data_i[6:4];
        b_lat_d = data_i[2:0];
        phase_d = PH_SECOND;
      end else begin
        pal_d[index_q] = {r_lat_q, data_i[2:0], b_lat_q};
        index_d        = index_q + 4'd1;
        phase_d        = PH_FIRST;
      end
    end
  end

  assign rd_dat_o = pal_q[rd_idx_i];

endmodule

// File: rtl/vdp_color_palette.sv
// Pixel back-end: layer select, sprite overlay, backdrop/blank/mask, palette or G7 direct colour to 5-bit RGB.
// Latency: 2 clk from sampled dot inputs to registered RGB.
// Backpressure: none; one dot per clock, never stalls.
module vdp_color_palette
  import vdp_palette_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        screen_active,
  input  logic [12:0] screen_pos_x,
  input  logic [3:0]  t12_display_color,
  input  logic [3:0]  g123m_display_color,
  input  logic [7:0]  g4567_display_color,
  input  logic [3:0]  sprite_display_color,
  input  logic        sprite_display_color_en,
  input  logic [4:0]  reg_screen_mode,
  input  logic        reg_display_on,
  input  logic [7:0]  reg_backdrop_color,
  input  logic        reg_color0_opaque,
  input  logic        reg_left_mask,
  input  logic        palette_index_wr,
  input  logic [3:0]  palette_index,
  input  logic        palette_wr,
  input  logic [7:0]  palette_wdata,
  output logic [4:0]  vdp_r,
  output logic [4:0]  vdp_g,
  output logic [4:0]  vdp_b,
  output logic        vdp_active
);

  // Sub-dot position bits carry no colour information here.
  logic unused_pos;
  assign unused_pos = ^screen_pos_x[3:0];

  logic [7:0] s1_code_q, s1_code_d;
  logic       s1_spr_q, s1_spr_d;
  logic       s1_g7_q, s1_g7_d;
  logic       s1_act_q;
  logic [4:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       act_q;

  logic       is_text;
  logic       blank;
  logic [7:0] layer_code;
  logic [7:0] backdrop;
  logic [8:0] pal_rd;
  logic [7:0] g7_byte;

  vdp_palette_writer u_writer (
    .clk        (clk),
    .reset_n    (reset_n),
    .index_wr_i (palette_index_wr),
    .index_i    (palette_index),
    .data_wr_i  (palette_wr),
    .data_i     (palette_wdata),
    .rd_idx_i   (s1_code_q[3:0]),
    .rd_dat_o   (pal_rd)
  );

  // S1: pick the layer code, overlay sprite, then apply transparency and blanking (blank wins).
  always_comb begin
    is_text = (reg_screen_mode == MODE_T1) || (reg_screen_mode == MODE_T2);
    s1_g7_d = (reg_screen_mode == MODE_G7);
    case (reg_screen_mode)
      MODE_T1, MODE_T2:                   layer_code = {4'h0, t12_display_color};
      MODE_G4, MODE_G6:                   layer_code = {4'h0, g4567_display_color[3:0]};
      MODE_G5:                            layer_code = {6'h00, g4567_display_color[1:0]};
      MODE_G7:                            layer_code = g4567_display_color;
      MODE_G1, MODE_G2, MODE_MC, MODE_G3: layer_code = {4'h0, g123m_display_color};
      default:                            layer_code = {4'h0, g123m_display_color};
    endcase
    backdrop  = s1_g7_d ? reg_backdrop_color : {4'h0, reg_backdrop_color[3:0]};
    blank     = !screen_active || !reg_display_on ||
                (reg_left_mask && (screen_pos_x[12:4] < 9'd8));
    s1_code_d = layer_code;
    s1_spr_d  = 1'b0;
    if (sprite_display_color_en && !is_text) begin
      s1_code_d = {4'h0, sprite_display_color};
      s1_spr_d  = 1'b1;
    end
    if ((s1_code_d == 8'h00) && !reg_color0_opaque) begin
      s1_code_d = backdrop;
      s1_spr_d  = 1'b0;
    end
    if (blank) begin
      s1_code_d = backdrop;
      s1_spr_d  = 1'b0;
    end
  end

  // S2: palette lookup, or G7 direct / G7 sprite table, expanded to 5-bit channels.
  always_comb begin
    g7_byte = s1_spr_q ? G7_SPRITE[s1_code_q[3:0]] : s1_code_q;
    if (s1_g7_q) begin
      r_d = expand3to5(g7_byte[4:2]);
      g_d = expand3to5(g7_byte[7:5]);
      b_d = {g7_byte[1:0], g7_byte[1:0], g7_byte[1]};
    end else begin
      r_d = expand3to5(pal_rd[8:6]);
      g_d = expand3to5(pal_rd[5:3]);
      b_d = expand3to5(pal_rd[2:0]);
    end
  end

  // Two pipeline register stages; screen_active travels alongside the colour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_code_q <= '0;
      s1_spr_q  <= 1'b0;
      s1_g7_q   <= 1'b0;
      s1_act_q  <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      act_q     <= 1'b0;
    end else begin
      s1_code_q <= s1_code_d;
      s1_spr_q  <= s1_spr_d;
      s1_g7_q   <= s1_g7_d;
      s1_act_q  <= screen_active;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      act_q     <= s1_act_q;
    end
  end

  assign vdp_r      = r_q;
  assign vdp_g      = g_q;
  assign vdp_b      = b_q;
  assign vdp_active = act_q;

endmodule
